// File: rtl/network_interface_pkg.sv
// Shared config for the mesh local-port endpoint: mesh size, packet_t layout,
// injection FSM states and a saturating counter helper.
// No ports; imported by the interface, the injection queue and the top.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

package network_interface_pkg;

  localparam int X_W       = $clog2(`X_NODES);
  localparam int Y_W       = $clog2(`Y_NODES);
  localparam int PKT_TS_W  = 16;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [X_W-1:0]       x_source;
    logic [Y_W-1:0]       y_source;
    logic [X_W-1:0]       x_dest;
    logic [Y_W-1:0]       y_dest;
    logic                 ant;
    logic [PKT_TS_W-1:0]  timestamp;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_STALL = 2'd2
  } tx_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/network_interface_if.sv
// Bundle of every handshake/bus signal between the endpoint, its node core
// and its router's local port. slave = the endpoint, master = its environment.
// Ports: core TX request, router inject/eject, core RX result, statistics.
interface network_interface_if #(
  parameter int TS_W = network_interface_pkg::PKT_TS_W
);
  import network_interface_pkg::*;

  // core -> endpoint TX request
  logic [X_W-1:0]  i_tx_x_dest;
  logic [Y_W-1:0]  i_tx_y_dest;
  logic            i_tx_ant;
  logic            i_tx_val;
  logic            o_tx_ready;
  // endpoint -> router local input
  packet_t         o_data;
  logic            o_data_val;
  logic            i_en;
  // router local output -> endpoint
  packet_t         i_data;
  logic            i_data_val;
  logic            o_en;
  // endpoint -> core RX result
  logic [X_W-1:0]  o_rx_src_x;
  logic [Y_W-1:0]  o_rx_src_y;
  logic [TS_W-1:0] o_rx_latency;
  logic            o_rx_ant;
  logic            o_rx_val;
  logic            i_rx_ready;
  // statistics
  logic [31:0]     o_tx_count;
  logic [31:0]     o_rx_count;
  logic            o_misroute;

  modport slave (
    input  i_tx_x_dest, i_tx_y_dest, i_tx_ant, i_tx_val, i_en,
           i_data, i_data_val, i_rx_ready,
    output o_tx_ready, o_data, o_data_val, o_en,
           o_rx_src_x, o_rx_src_y, o_rx_latency, o_rx_ant, o_rx_val,
           o_tx_count, o_rx_count, o_misroute
  );

  modport master (
    output i_tx_x_dest, i_tx_y_dest, i_tx_ant, i_tx_val, i_en,
           i_data, i_data_val, i_rx_ready,
    input  o_tx_ready, o_data, o_data_val, o_en,
           o_rx_src_x, o_rx_src_y, o_rx_latency, o_rx_ant, o_rx_val,
           o_tx_count, o_rx_count, o_misroute
  );

endinterface

// File: rtl/network_interface_fifo.sv
// Packet FIFO (fifo_packet): push on i_data_val && o_en, pop on o_data_val && i_en.
// Latency: a push is visible at the head one cycle later when empty.
// Backpressure: o_en = not full; head holds stable while i_en is low.
module fifo_packet
  import network_interface_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  packet_t                i_data,
  input  logic                   i_data_val,
  output logic                   o_en,
  output packet_t                o_data,
  output logic                   o_data_val,
  input  logic                   i_en,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  packet_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;

  // Extra pointer MSB separates full from empty; wrap is natural.
  assign o_count    = wr_ptr - rd_ptr;
  assign o_en       = (o_count != (AW+1)'(DEPTH));
  assign o_data_val = (wr_ptr != rd_ptr);
  assign o_data     = mem[rd_ptr[AW-1:0]];
  assign push       = i_data_val & o_en;
  assign pop        = o_data_val & i_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read past the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/network_interface.sv
// Local-port endpoint: stamps and queues core packets for injection, ejects router packets to the core.
// Latency: accept->o_data_val 1 cycle (empty queue); eject->o_rx_val 1 cycle.
// Backpressure: o_tx_ready = queue not full; o_en = RX register free or being consumed.
// Ports: clk, reset_n (async active-low), nif (slave side of network_interface_if).
module network_interface
  import network_interface_pkg::*;
#(
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int TX_DEPTH = 4,
  parameter int TS_W     = PKT_TS_W
) (
  input  logic                clk,
  input  logic                reset_n,
  network_interface_if.slave  nif
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [TS_W-1:0] ts;
  logic            run_q;

  packet_t         tx_pkt;
  packet_t         head;
  logic            fifo_push;
  logic            fifo_rdy;
  logic            fifo_val;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;
  tx_state_e       state;
  tx_state_e       state_nxt;
  logic            data_val;
  logic [31:0]     tx_count;

  logic            rx_en;
  logic            rx_load;
  logic            rx_val;
  logic [X_W-1:0]  rx_src_x;
  logic [Y_W-1:0]  rx_src_y;
  logic [TS_W-1:0] rx_latency;
  logic            rx_ant;
  logic [31:0]     rx_count;
  logic            misroute;

  // run_q keeps both ready outputs low through reset and raises them on the
  // first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts    <= '0;
      run_q <= 1'b0;
    end else begin
      ts    <= ts + 1'b1;
      run_q <= 1'b1;
    end
  end

  // ---------------- TX: stamp, queue, inject ----------------
  always_comb begin
    tx_pkt           = '0;
    tx_pkt.x_source  = X_W'(X_LOC);
    tx_pkt.y_source  = Y_W'(Y_LOC);
    tx_pkt.x_dest    = nif.i_tx_x_dest;
    tx_pkt.y_dest    = nif.i_tx_y_dest;
    tx_pkt.ant       = nif.i_tx_ant;
    tx_pkt.timestamp = PKT_TS_W'(ts);
  end

  assign fifo_push = nif.i_tx_val & run_q;

  fifo_packet #(.DEPTH(TX_DEPTH)) u_tx_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_data     (tx_pkt),
    .i_data_val (fifo_push),
    .o_en       (fifo_rdy),
    .o_data     (head),
    .o_data_val (fifo_val),
    .i_en       (nif.i_en),
    .o_count    (fifo_count)
  );

  assign push = fifo_push & fifo_rdy;
  assign pop  = fifo_val & nif.i_en;

  // The FSM leaves IDLE exactly when the queue turns non-empty and returns
  // on the last pop, so it doubles as the head-valid flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= TX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TX_IDLE: begin
        if (push) state_nxt = nif.i_en ? TX_SEND : TX_STALL;
      end
      TX_SEND, TX_STALL: begin
        if (pop && !push && fifo_count == CW'(1)) state_nxt = TX_IDLE;
        else                                      state_nxt = nif.i_en ? TX_SEND : TX_STALL;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign data_val       = (state != TX_IDLE);
  assign nif.o_data_val = data_val;
  assign nif.o_data     = data_val ? head : '0;
  assign nif.o_tx_ready = run_q & fifo_rdy;

  // ---------------- RX: single-entry buffer, pass-through ready ----------------
  assign rx_en   = run_q & (~rx_val | nif.i_rx_ready);
  assign rx_load = nif.i_data_val & rx_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_val     <= 1'b0;
      rx_src_x   <= '0;
      rx_src_y   <= '0;
      rx_latency <= '0;
      rx_ant     <= 1'b0;
      rx_count   <= '0;
      misroute   <= 1'b0;
      tx_count   <= '0;
    end else begin
      if (rx_load) begin
        rx_val     <= 1'b1;
        rx_src_x   <= nif.i_data.x_source;
        rx_src_y   <= nif.i_data.y_source;
        rx_ant     <= nif.i_data.ant;
        // Unsigned subtraction gives the modulo-2^TS_W distance across ts wrap.
        rx_latency <= ts - TS_W'(nif.i_data.timestamp);
        rx_count   <= sat_inc(rx_count);
        if (nif.i_data.x_dest != X_W'(X_LOC) || nif.i_data.y_dest != Y_W'(Y_LOC))
          misroute <= 1'b1;
      end else if (nif.i_rx_ready) begin
        rx_val <= 1'b0;
      end
      if (pop) tx_count <= sat_inc(tx_count);
    end
  end

  assign nif.o_en         = rx_en;
  assign nif.o_rx_val     = rx_val;
  assign nif.o_rx_src_x   = rx_src_x;
  assign nif.o_rx_src_y   = rx_src_y;
  assign nif.o_rx_latency = rx_latency;
  assign nif.o_rx_ant     = rx_ant;
  assign nif.o_rx_count   = rx_count;
  assign nif.o_tx_count   = tx_count;
  assign nif.o_misroute   = misroute;

endmodule

// File: tb/tb_network_interface.sv
module tb_network_interface;
  import network_interface_pkg::*;

  localparam int XL    = 1;
  localparam int YL    = 2;
  localparam int DEPTH = 4;
  localparam int TSW   = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  network_interface_if #(.TS_W(TSW)) nif ();

  network_interface #(
    .X_LOC(XL), .Y_LOC(YL), .TX_DEPTH(DEPTH), .TS_W(TSW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .nif     (nif)
  );

  always #5 clk = ~clk;

  // Reference time base: cycles since reset release, modulo 2^TSW.
  logic [TSW-1:0] tb_ts;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 1'b1;
  end

  int checks = 0;
  int errors = 0;

  packet_t        txq[$];
  int             exp_tx = 0;
  int             exp_rx = 0;
  packet_t        p, pa, pb;
  logic [TSW-1:0] t, exp_lat;
  bit             v, e, do_push, do_pop;
  bit             sv;
  packet_t        sp;
  logic [TSW-1:0] sl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk_tx(input logic [X_W-1:0] xd, input logic [Y_W-1:0] yd,
                                    input logic ant, input logic [TSW-1:0] stamp);
    packet_t r;
    r           = '0;
    r.x_source  = X_W'(XL);
    r.y_source  = Y_W'(YL);
    r.x_dest    = xd;
    r.y_dest    = yd;
    r.ant       = ant;
    r.timestamp = stamp;
    return r;
  endfunction

  function automatic packet_t mk_rx(input logic [X_W-1:0] xd, input logic [Y_W-1:0] yd,
                                    input logic [TSW-1:0] stamp);
    packet_t r;
    r           = '0;
    r.x_source  = X_W'($urandom);
    r.y_source  = Y_W'($urandom);
    r.x_dest    = xd;
    r.y_dest    = yd;
    r.ant       = 1'($urandom);
    r.timestamp = stamp;
    r.payload   = PAYLOAD_W'($urandom);
    return r;
  endfunction

  task automatic drive_tx(input bit val);
    nif.i_tx_val    = val;
    nif.i_tx_x_dest = X_W'($urandom);
    nif.i_tx_y_dest = Y_W'($urandom);
    nif.i_tx_ant    = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nif.i_tx_x_dest = '0; nif.i_tx_y_dest = '0; nif.i_tx_ant = 1'b0; nif.i_tx_val = 1'b0;
    nif.i_en = 1'b0; nif.i_data = '0; nif.i_data_val = 1'b0; nif.i_rx_ready = 1'b0;

    // ---- reset state ----
    #12;
    chk("rst_data_val", nif.o_data_val, 0);
    chk("rst_rx_val",   nif.o_rx_val,   0);
    chk("rst_en",       nif.o_en,       0);
    chk("rst_tx_ready", nif.o_tx_ready, 0);
    chk("rst_tx_count", nif.o_tx_count, 0);
    chk("rst_rx_count", nif.o_rx_count, 0);
    chk("rst_misroute", nif.o_misroute, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    chk("rel_tx_ready", nif.o_tx_ready, 1);
    chk("rel_en",       nif.o_en,       1);

    // ---- basic inject at ts=5 ----
    for (int i = 0; i < 20 && tb_ts != 5; i++) tick();
    chk("wait_ts5", tb_ts, 5);
    nif.i_en = 1'b1;
    nif.i_tx_val = 1'b1; nif.i_tx_x_dest = 2'd2; nif.i_tx_y_dest = 2'd1; nif.i_tx_ant = 1'b0;
    p = mk_tx(2'd2, 2'd1, 1'b0, tb_ts);
    tick();
    nif.i_tx_val = 1'b0;
    chk("basic_val",   nif.o_data_val, 1);
    chk("basic_ts",    nif.o_data.timestamp, 5);
    chk("basic_xsrc",  nif.o_data.x_source, XL);
    chk("basic_pkt",   64'(nif.o_data), 64'(p));
    chk("basic_cnt0",  nif.o_tx_count, 0);
    tick();
    exp_tx = 1;
    chk("basic_cnt1",  nif.o_tx_count, exp_tx);
    chk("basic_empty", nif.o_data_val, 0);

    // ---- backpressure: 5 requests into a 4-deep queue with i_en low ----
    nif.i_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_tx(1'b1);
      chk("bp_ready", nif.o_tx_ready, (txq.size() < DEPTH));
      if (txq.size() < DEPTH) txq.push_back(mk_tx(nif.i_tx_x_dest, nif.i_tx_y_dest, nif.i_tx_ant, tb_ts));
      tick();
    end
    nif.i_tx_val = 1'b0;
    chk("bp_full", nif.o_tx_ready, 0);
    chk("bp_head", 64'(nif.o_data), 64'(txq[0]));
    tick(); tick();
    chk("bp_hold", 64'(nif.o_data), 64'(txq[0]));
    nif.i_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("bp_drain_val", nif.o_data_val, 1);
      chk("bp_drain_pkt", 64'(nif.o_data), 64'(txq[0]));
      tick();
      void'(txq.pop_front());
      exp_tx++;
    end
    chk("bp_done_val", nif.o_data_val, 0);
    chk("bp_count",    nif.o_tx_count, exp_tx);

    // ---- randomized TX traffic against queue model ----
    for (int c = 0; c < 60; c++) begin
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      drive_tx(v);
      nif.i_en = e;
      chk("rnd_ready", nif.o_tx_ready, (txq.size() < DEPTH));
      chk("rnd_val",   nif.o_data_val, (txq.size() != 0));
      if (txq.size() != 0) chk("rnd_head", 64'(nif.o_data), 64'(txq[0]));
      do_push = v && (txq.size() < DEPTH);
      do_pop  = e && (txq.size() != 0);
      p = mk_tx(nif.i_tx_x_dest, nif.i_tx_y_dest, nif.i_tx_ant, tb_ts);
      tick();
      if (do_pop)  begin void'(txq.pop_front()); exp_tx++; end
      if (do_push) txq.push_back(p);
    end
    nif.i_tx_val = 1'b0;
    nif.i_en = 1'b1;
    for (int i = 0; i < 8 && txq.size() != 0; i++) begin
      tick();
      void'(txq.pop_front());
      exp_tx++;
    end
    chk("rnd_drained", nif.o_data_val, 0);
    chk("rnd_count",   nif.o_tx_count, exp_tx);

    // ---- eject with latency 15 ----
    nif.i_rx_ready = 1'b1;
    p = mk_rx(X_W'(XL), Y_W'(YL), tb_ts - 16'd15);
    nif.i_data = p; nif.i_data_val = 1'b1;
    #1;
    chk("ej_en", nif.o_en, 1);
    tick();
    nif.i_data_val = 1'b0;
    exp_rx++;
    chk("ej_val",   nif.o_rx_val, 1);
    chk("ej_lat",   nif.o_rx_latency, 15);
    chk("ej_srcx",  nif.o_rx_src_x, p.x_source);
    chk("ej_srcy",  nif.o_rx_src_y, p.y_source);
    chk("ej_ant",   nif.o_rx_ant, p.ant);
    chk("ej_mis",   nif.o_misroute, 0);
    chk("ej_count", nif.o_rx_count, exp_rx);
    tick();
    chk("ej_consumed", nif.o_rx_val, 0);

    // ---- RX stall: two back-to-back packets, core not ready ----
    nif.i_rx_ready = 1'b0;
    pa = mk_rx(X_W'(XL), Y_W'(YL), tb_ts - 16'd3);
    nif.i_data = pa; nif.i_data_val = 1'b1;
    tick();
    exp_rx++;
    pb = mk_rx(X_W'(XL), Y_W'(YL), tb_ts - 16'd7);
    nif.i_data = pb;
    #1;
    chk("st_en_low", nif.o_en, 0);
    tick();
    chk("st_hold_lat", nif.o_rx_latency, 3);
    chk("st_hold_src", nif.o_rx_src_x, pa.x_source);
    chk("st_en_low2",  nif.o_en, 0);
    nif.i_rx_ready = 1'b1;
    #1;
    chk("st_en_pass", nif.o_en, 1);
    exp_lat = tb_ts - pb.timestamp;
    tick();
    nif.i_data_val = 1'b0;
    exp_rx++;
    chk("st_b_val",   nif.o_rx_val, 1);
    chk("st_b_src",   nif.o_rx_src_y, pb.y_source);
    chk("st_b_lat",   nif.o_rx_latency, exp_lat);
    chk("st_count",   nif.o_rx_count, exp_rx);
    tick();
    chk("st_empty",   nif.o_rx_val, 0);

    // ---- randomized RX traffic against single-slot model ----
    sv = 1'b0; sp = '0; sl = '0;
    for (int c = 0; c < 40; c++) begin
      v = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      p = mk_rx(X_W'(XL), Y_W'(YL), TSW'($urandom));
      nif.i_data = p; nif.i_data_val = v; nif.i_rx_ready = e;
      #1;
      chk("rrx_en",  nif.o_en, (!sv || e));
      chk("rrx_val", nif.o_rx_val, sv);
      if (sv) begin
        chk("rrx_lat", nif.o_rx_latency, sl);
        chk("rrx_src", {nif.o_rx_src_x, nif.o_rx_src_y, nif.o_rx_ant}, {sp.x_source, sp.y_source, sp.ant});
      end
      do_push = v && (!sv || e);
      t = tb_ts;
      tick();
      if (do_push) begin sv = 1'b1; sp = p; sl = t - p.timestamp; exp_rx++; end
      else if (e)  sv = 1'b0;
    end
    nif.i_data_val = 1'b0;
    chk("rrx_count", nif.o_rx_count, exp_rx);
    chk("rrx_nomis", nif.o_misroute, 0);

    // ---- misroute is sticky and the packet is still delivered ----
    nif.i_rx_ready = 1'b1;
    p = mk_rx(X_W'((XL + 1) % `X_NODES), Y_W'(YL), tb_ts);
    nif.i_data = p; nif.i_data_val = 1'b1;
    tick();
    nif.i_data_val = 1'b0;
    exp_rx++;
    chk("mis_set", nif.o_misroute, 1);
    chk("mis_del", nif.o_rx_val, 1);
    chk("mis_src", nif.o_rx_src_x, p.x_source);
    tick(); tick(); tick();
    chk("mis_sticky", nif.o_misroute, 1);
    chk("mis_count",  nif.o_rx_count, exp_rx);

    // ---- async reset mid-transfer ----
    nif.i_en = 1'b0;
    drive_tx(1'b1);
    tick();
    drive_tx(1'b1);
    tick();
    nif.i_tx_val = 1'b0;
    nif.i_rx_ready = 1'b0;
    nif.i_data = mk_rx(X_W'(XL), Y_W'(YL), tb_ts); nif.i_data_val = 1'b1;
    tick();
    nif.i_data_val = 1'b0;
    chk("pre_rst_val", nif.o_data_val, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_data_val", nif.o_data_val, 0);
    chk("ar_data",     64'(nif.o_data), 0);
    chk("ar_tx_ready", nif.o_tx_ready, 0);
    chk("ar_en",       nif.o_en, 0);
    chk("ar_rx_val",   nif.o_rx_val, 0);
    chk("ar_tx_count", nif.o_tx_count, 0);
    chk("ar_rx_count", nif.o_rx_count, 0);
    chk("ar_misroute", nif.o_misroute, 0);
    txq.delete();
    nif.i_en = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    chk("ar2_empty",    nif.o_data_val, 0);
    chk("ar2_tx_ready", nif.o_tx_ready, 1);
    chk("ar2_rx_val",   nif.o_rx_val, 0);
    tick();
    chk("ar2_no_replay", nif.o_tx_count, 0);

    // ---- latency wrap: stamp 0xFFF0 ejected at ts=0x0005 ----
    nif.i_rx_ready = 1'b1;
    for (int i = 0; i < 20 && tb_ts != 5; i++) tick();
    chk("wrap_wait_ts5", tb_ts, 5);
    p = mk_rx(X_W'(XL), Y_W'(YL), 16'hFFF0);
    nif.i_data = p; nif.i_data_val = 1'b1;
    tick();
    nif.i_data_val = 1'b0;
    chk("wrap_val",   nif.o_rx_val, 1);
    chk("wrap_lat",   nif.o_rx_latency, 16'h0015);
    chk("wrap_count", nif.o_rx_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
